// File: rtl/ddr_region_loader.sv
// Purpose: walks a descriptor table and copies each region's input words to the DDR write port as narrow beats, LS lane first.
// Latency: first beat three cycles after start with s_valid high; BEATS+1 cycles per word, plus one cycle per LOAD.
// Backpressure: s_ready only in ACCEPT; m_wr_* are held while m_wr_ready is low. Optional DDR_LOADER_CHECKSUM_EN adds chk_sum/chk_valid.
`timescale 1ns/1ps

module ddr_region_loader #(
   parameter int PORT_DATAWIDTH = 128,
   parameter int OUT_WIDTH      = 8,
   parameter int NUM_REGION     = 5,
   parameter int ADDR_WIDTH     = 32,
   parameter int LEN_WIDTH      = 20,
   parameter logic [ADDR_WIDTH-1:0] DDR_OFFSET = ADDR_WIDTH'(32'h0800_0000),
   localparam int BEATS     = PORT_DATAWIDTH / OUT_WIDTH,
   localparam int OUT_BYTES = OUT_WIDTH / 8,
   localparam int IDX_W     = (NUM_REGION > 1) ? $clog2(NUM_REGION) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cfg_wr,
   input  logic [IDX_W-1:0]          cfg_idx,
   input  logic [ADDR_WIDTH-1:0]     cfg_base,
   input  logic [LEN_WIDTH-1:0]      cfg_len,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic [IDX_W-1:0]          cur_region,
`ifdef DDR_LOADER_CHECKSUM_EN
   output logic [31:0]               chk_sum,
   output logic                      chk_valid,
`endif
   input  logic                      s_valid,
   input  logic [PORT_DATAWIDTH-1:0] s_data,
   output logic                      s_ready,
   output logic                      m_wr_en,
   output logic [ADDR_WIDTH-1:0]     m_wr_addr,
   output logic [OUT_WIDTH-1:0]      m_wr_data,
   input  logic                      m_wr_ready
);

   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ACCEPT,
      S_EMIT,
      S_DONE
   } state_t;

   state_t                      state_q;
   logic [ADDR_WIDTH-1:0]       base_q [NUM_REGION];
   logic [LEN_WIDTH-1:0]        len_q  [NUM_REGION];
   logic [IDX_W-1:0]            region_q;
   logic [LEN_WIDTH-1:0]        word_q;
   logic [BEAT_W-1:0]           beat_q;
   logic [PORT_DATAWIDTH-1:0]   word_dat_q;
   logic [ADDR_WIDTH-1:0]       addr_q;
   logic                        busy_q;
   logic                        done_q;
   logic                        s_ready_q;
   logic                        m_wr_en_q;
   logic [OUT_WIDTH-1:0]        m_wr_data_q;

   logic [ADDR_WIDTH-1:0]       cur_base;
   logic [LEN_WIDTH-1:0]        cur_len;
   logic [IDX_W-1:0]            region_d;
   logic [LEN_WIDTH-1:0]        word_d;
   logic [BEAT_W-1:0]           beat_d;
   logic                        region_last;
   logic                        beat_last;
   logic                        word_last;
   logic [OUT_WIDTH-1:0]        next_slice;

   // Descriptor lookup and counter increments shared by the FSM and the checksum.
   always_comb begin
      cur_base    = base_q[region_q];
      cur_len     = len_q[region_q];
      region_d    = region_q + 1'b1;
      word_d      = word_q + 1'b1;
      beat_d      = beat_q + 1'b1;
      region_last = (region_q == IDX_W'(NUM_REGION - 1));
      beat_last   = (beat_q == BEAT_W'(BEATS - 1));
      word_last   = beat_last && (word_d == cur_len);
      next_slice  = word_dat_q[OUT_WIDTH*int'(beat_d) +: OUT_WIDTH];
   end

   // Descriptor table: writable only while idle, so a running walk sees a frozen table.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGION; i++) begin
            base_q[i] <= '0;
            len_q[i]  <= '0;
         end
      end else if (cfg_wr && (state_q == S_IDLE) && (int'(cfg_idx) < NUM_REGION)) begin
         base_q[cfg_idx] <= cfg_base;
         len_q[cfg_idx]  <= cfg_len;
      end
   end

   // Main sequencer: region walk, word capture and beat emission with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         region_q    <= '0;
         word_q      <= '0;
         beat_q      <= '0;
         word_dat_q  <= '0;
         addr_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         s_ready_q   <= 1'b0;
         m_wr_en_q   <= 1'b0;
         m_wr_data_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  region_q <= '0;
                  word_q   <= '0;
                  beat_q   <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (cur_len == '0) begin
                  if (region_last) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     region_q <= region_d;
                  end
               end else begin
                  // Rebase wraps silently modulo 2^ADDR_WIDTH.
                  addr_q    <= cur_base - DDR_OFFSET;
                  word_q    <= '0;
                  s_ready_q <= 1'b1;
                  state_q   <= S_ACCEPT;
               end
            end
            S_ACCEPT: begin
               if (s_valid) begin
                  word_dat_q  <= s_data;
                  beat_q      <= '0;
                  s_ready_q   <= 1'b0;
                  m_wr_en_q   <= 1'b1;
                  m_wr_data_q <= s_data[OUT_WIDTH-1:0];
                  state_q     <= S_EMIT;
               end
            end
            S_EMIT: begin
               if (m_wr_ready) begin
                  addr_q <= addr_q + ADDR_WIDTH'(OUT_BYTES);
                  if (beat_last) begin
                     m_wr_en_q <= 1'b0;
                     word_q    <= word_d;
                     if (word_last) begin
                        // Last region with data finishes directly; nothing left to load.
                        if (region_last) begin
                           busy_q  <= 1'b0;
                           done_q  <= 1'b1;
                           state_q <= S_DONE;
                        end else begin
                           region_q <= region_d;
                           state_q  <= S_LOAD;
                        end
                     end else begin
                        s_ready_q <= 1'b1;
                        state_q   <= S_ACCEPT;
                     end
                  end else begin
                     beat_q      <= beat_d;
                     m_wr_data_q <= next_slice;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign cur_region = region_q;
   assign s_ready    = s_ready_q;
   assign m_wr_en    = m_wr_en_q;
   assign m_wr_addr  = addr_q;
   assign m_wr_data  = m_wr_data_q;

`ifdef DDR_LOADER_CHECKSUM_EN
   logic        beat_fire;
   logic [31:0] acc_q;
   logic [31:0] acc_d;
   logic [31:0] chk_sum_q;
   logic        chk_valid_q;

   // Running sum including the beat being accepted this cycle.
   always_comb begin
      beat_fire = (state_q == S_EMIT) && m_wr_ready;
      acc_d     = acc_q + 32'(m_wr_data_q);
   end

   // Per-region checksum: cleared when a region with data is loaded, published after its final beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q       <= '0;
         chk_sum_q   <= '0;
         chk_valid_q <= 1'b0;
      end else begin
         chk_valid_q <= 1'b0;
         if ((state_q == S_LOAD) && (cur_len != '0)) begin
            acc_q <= '0;
         end else if (beat_fire) begin
            acc_q <= acc_d;
            if (word_last) begin
               chk_sum_q   <= acc_d;
               chk_valid_q <= 1'b1;
            end
         end
      end
   end

   assign chk_sum   = chk_sum_q;
   assign chk_valid = chk_valid_q;
`endif

endmodule
